// File: rtl/bcd_counter_mux.sv
// N-digit BCD up/down counter with tick prescaler, parallel load and a
// multiplexed active-low 7-segment driver. Optional macro: BCD_LEADING_ZERO_BLANK_EN.
module bcd_counter_mux #(
    parameter int DIGITS    = 4,
    parameter int CLK_HZ    = 50_000_000,
    parameter int TICK_HZ   = 4,
    parameter int SCAN_LOG2 = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tick,
    output logic                  wrap,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int DIV       = CLK_HZ / TICK_HZ;
    localparam int PW        = $clog2(DIV);
    localparam int IDXW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SW        = SCAN_LOG2 + IDXW;
    localparam int SCAN_LAST = DIGITS * (2 ** SCAN_LOG2) - 1;

    // One BCD step over all digits; the top bit is the final carry/borrow,
    // which is set exactly when the value wrapped.
    function automatic logic [4*DIGITS:0] bcd_step(input logic [4*DIGITS-1:0] v,
                                                   input logic dir_up);
        logic [4*DIGITS-1:0] r;
        logic                c;
        logic [3:0]          d;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (c) begin
                if (dir_up) begin
                    if (d == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = d + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        r[4*i +: 4] = 4'd9;
                    end else begin
                        r[4*i +: 4] = d - 4'd1;
                        c = 1'b0;
                    end
                end
            end else begin
                r[4*i +: 4] = d;
            end
        end
        return {c, r};
    endfunction

    function automatic logic [4*DIGITS-1:0] sanitize(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd0 : v[4*i +: 4];
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

`ifdef BCD_LEADING_ZERO_BLANK_EN
    // Bit i set when digit i and everything above it are zero; digit 0 never blanks.
    function automatic logic [DIGITS-1:0] lead_zero(input logic [4*DIGITS-1:0] v);
        logic [DIGITS-1:0] r;
        logic              nz;
        nz = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nz   = nz | (v[4*i +: 4] != 4'd0);
            r[i] = ~nz & (i != 0);
        end
        return r;
    endfunction
`endif

    logic [PW-1:0]         presc_q, presc_d;
    logic                  tick_q, tick_d;
    logic [4*DIGITS-1:0]   count_q, count_d;
    logic                  wrap_q, wrap_d;
    logic [SW-1:0]         scan_q, scan_d;
    logic [4*DIGITS:0]     step_s;
    logic [IDXW-1:0]       idx_s;
    logic [3:0]            digit_s;
    logic                  blank_s;

    // Prescaler and tick pulse: free-running, independent of en/load.
    always_comb begin
        if (presc_q == PW'(DIV - 1)) begin
            presc_d = '0;
            tick_d  = 1'b1;
        end else begin
            presc_d = presc_q + PW'(1);
            tick_d  = 1'b0;
        end
    end

    // Counter next state: load beats a step, wrap only on a real step.
    always_comb begin
        step_s = bcd_step(count_q, up);
        if (load) begin
            count_d = sanitize(load_val);
            wrap_d  = 1'b0;
        end else if (tick_q && en) begin
            count_d = step_s[4*DIGITS-1:0];
            wrap_d  = step_s[4*DIGITS];
        end else begin
            count_d = count_q;
            wrap_d  = 1'b0;
        end
    end

    // Scan counter wraps explicitly so non-power-of-2 digit counts work.
    always_comb begin
        if (scan_q == SW'(SCAN_LAST)) begin
            scan_d = '0;
        end else begin
            scan_d = scan_q + SW'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            count_q <= '0;
            wrap_q  <= 1'b0;
            scan_q  <= '0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
            scan_q  <= scan_d;
        end
    end

    assign idx_s = scan_q[SW-1:SCAN_LOG2];

    // Display mux: anode select, digit select and blanking from registers.
    always_comb begin
        an      = '1;
        digit_s = 4'd0;
        blank_s = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_s == IDXW'(i)) begin
                an[i]   = 1'b0;
                digit_s = count_q[4*i +: 4];
`ifdef BCD_LEADING_ZERO_BLANK_EN
                blank_s = lead_zero(count_q)[i];
`else
                blank_s = 1'b0;
`endif
            end else begin
                an[i] = 1'b1;
            end
        end
        if (blank_s) begin
            seg = 7'h7F;
        end else begin
            seg = seg_decode(digit_s);
        end
    end

    assign count = count_q;
    assign tick  = tick_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_bcd_counter_mux.sv
// Self-checking bench for bcd_counter_mux (DIGITS=3, DIV=4, SCAN_LOG2=2):
// a decimal-arithmetic model checked every cycle plus literal checkpoints.
module tb_bcd_counter_mux;

    localparam int DIGITS    = 3;
    localparam int CLK_HZ    = 8;
    localparam int TICK_HZ   = 2;
    localparam int SCAN_LOG2 = 2;
    localparam int DIV       = CLK_HZ / TICK_HZ;
    localparam int DWELL     = 2 ** SCAN_LOG2;
    localparam int MODV      = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        up = 1'b1;
    logic        load = 1'b0;
    logic [11:0] load_val = 12'h000;
    logic [11:0] count;
    logic        tick;
    logic        wrap;
    logic [6:0]  seg;
    logic [2:0]  an;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model state: decimal value and cycles since reset release.
    int   m_val  = 0;
    int   m_cyc  = 0;
    logic m_tick = 1'b0;
    logic m_wrap = 1'b0;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    bcd_counter_mux #(
        .DIGITS(DIGITS), .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .SCAN_LOG2(SCAN_LOG2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count), .tick(tick), .wrap(wrap),
        .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [11:0] bcd_of(input int v);
        logic [11:0] r;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic int load_dec(input logic [11:0] lv);
        int r = 0;
        int n;
        for (int i = 0; i < DIGITS; i++) begin
            n = int'(lv[4*i +: 4]);
            if (n > 9) n = 0;
            r = r + n * pow10(i);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model advanced on the same edges as the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_val  <= 0;
            m_cyc  <= 0;
            m_tick <= 1'b0;
            m_wrap <= 1'b0;
        end else begin
            m_cyc  <= m_cyc + 1;
            m_tick <= ((m_cyc + 1) % DIV) == 0;
            if (load) begin
                m_val  <= load_dec(load_val);
                m_wrap <= 1'b0;
            end else if (m_tick && en) begin
                if (up) begin
                    m_val  <= (m_val + 1) % MODV;
                    m_wrap <= (m_val == MODV - 1);
                end else begin
                    m_val  <= (m_val + MODV - 1) % MODV;
                    m_wrap <= (m_val == 0);
                end
            end else begin
                m_wrap <= 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        int         idx;
        logic [6:0] exp_seg;
        logic [2:0] exp_an;
        if (chk_en) begin
            idx     = (m_cyc % (DIGITS * DWELL)) / DWELL;
            exp_an  = ~(3'b001 << idx);
            exp_seg = seg_tab[(m_val / pow10(idx)) % 10];
`ifdef BCD_LEADING_ZERO_BLANK_EN
            if (idx > 0 && m_val < pow10(idx)) exp_seg = 7'h7F;
`endif
            check("m_count", 32'(count), 32'(bcd_of(m_val)));
            check("m_tick", 32'(tick), 32'(m_tick));
            check("m_wrap", 32'(wrap), 32'(m_wrap));
            check("m_an", 32'(an), 32'(exp_an));
            check("m_seg", 32'(seg), 32'(exp_seg));
        end
    end

    task automatic do_load(input logic [11:0] v);
        load_val = v;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    initial begin
        bit         found;
        logic [6:0] blank_exp;

        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_count", 32'(count), 32'h000);
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_wrap", 32'(wrap), 32'h0);
        check("rst_an", 32'(an), 32'h6);
        check("rst_seg", 32'(seg), 32'h40);

        // Free count: ten ticks sampled after 41 edges.
        rst_n = 1'b1;
        en    = 1'b1;
        up    = 1'b1;
        repeat (41) @(negedge clk);
        check("ten_ticks", 32'(count), 32'h010);

        // Up wrap from 998.
        do_load(12'h998);
        check("load_998", 32'(count), 32'h998);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (wrap) found = 1'b1;
        end
        check("up_wrap_seen", 32'(found), 32'h1);
        check("up_wrap_count", 32'(count), 32'h000);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (count != 12'h000) found = 1'b1;
        end
        check("after_wrap_count", 32'(count), 32'h001);
        check("after_wrap_wrap", 32'(wrap), 32'h0);

        // Down wrap from 000.
        up = 1'b0;
        do_load(12'h000);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (wrap) found = 1'b1;
        end
        check("dn_wrap_seen", 32'(found), 32'h1);
        check("dn_wrap_count", 32'(count), 32'h999);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (count != 12'h999) found = 1'b1;
        end
        check("dn_after_count", 32'(count), 32'h998);

        // Load with an invalid digit on a tick cycle: load wins.
        up    = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (tick) found = 1'b1;
        end
        check("tick_seen", 32'(found), 32'h1);
        do_load(12'h1A5);
        check("load_tick_count", 32'(count), 32'h105);
        check("load_tick_wrap", 32'(wrap), 32'h0);

        // Scan of 123 with counting frozen.
        en = 1'b0;
        do_load(12'h123);
        for (int i = 0; i < 3 * DWELL; i++) begin
            @(negedge clk);
            case (an)
                3'b110:  check("scan123_d0", 32'(seg), 32'h30);
                3'b101:  check("scan123_d1", 32'(seg), 32'h24);
                3'b011:  check("scan123_d2", 32'(seg), 32'h79);
                default: check("scan123_an", 32'(an), 32'h6);
            endcase
        end

        // Leading digits of 007.
`ifdef BCD_LEADING_ZERO_BLANK_EN
        blank_exp = 7'h7F;
`else
        blank_exp = 7'h40;
`endif
        do_load(12'h007);
        for (int i = 0; i < 3 * DWELL; i++) begin
            @(negedge clk);
            case (an)
                3'b110:  check("scan007_d0", 32'(seg), 32'h78);
                3'b101:  check("scan007_d1", 32'(seg), 32'(blank_exp));
                3'b011:  check("scan007_d2", 32'(seg), 32'(blank_exp));
                default: check("scan007_an", 32'(an), 32'h6);
            endcase
        end

        // Asynchronous reset mid-scan with a step pending.
        en = 1'b1;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'h000);
        check("arst_tick", 32'(tick), 32'h0);
        check("arst_wrap", 32'(wrap), 32'h0);
        check("arst_an", 32'(an), 32'h6);
        check("arst_seg", 32'(seg), 32'h40);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_counter_mux.md
# bcd_counter_mux

Parametrised N-digit BCD up/down counter with a built-in tick prescaler, synchronous parallel load, and a time-multiplexed 7-segment display driver.

- Counting is digit-wise BCD, with no binary-to-BCD division.
- Successor to the fixed 3-digit, up-only display counter.
- Sits between board-level controls (enable, direction, load) and the multiplexed common-anode display pins.

## Interface
- DIGITS, 4, number of BCD digits (1..8).
- CLK_HZ, 50_000_000, input clock frequency.
- TICK_HZ, 4, count rate. DIV = CLK_HZ/TICK_HZ, must be ≥ 2.
- SCAN_LOG2, 18, digit dwell is 2^SCAN_LOG2 clk cycles (≥ 1).
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  count enable, sampled on tick cycles.
- up  in  1  direction: 1 counts up, 0 counts down.
- load  in  1  synchronous load strobe.
- load_val  in  4*DIGITS  BCD load value; digit 0 is in bits [3:0].
- count  out  4*DIGITS  current BCD value, registered.
- tick  out  1  one-cycle prescaler pulse, registered.
- wrap  out  1  one-cycle pulse on 99..9→0 (up) or 0→99..9 (down), registered.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- an  out  DIGITS  digit anodes, active-low one-hot.

## Operation
- **Prescaler**
  - Counter runs 0..DIV-1, then returns to 0.
  - tick is registered high for exactly one cycle on the edge where the prescaler returns to 0. Period is DIV cycles.
  - The prescaler free-runs regardless of en and load.
- **Counting**
  - On an edge with tick=1, en=1, load=0, the counter steps once in the direction given by up.
  - Up: digit 0 +1. A digit at 9 becomes 0 and carries into the next digit.
  - Down: digit 0 −1. A digit at 0 becomes 9 and borrows from the next digit.
  - All digits update on the same edge.
- **Wrap**
  - Up from all-9s gives all-0s; down from all-0s gives all-9s.
  - wrap is registered high on that same edge and lasts one cycle.
- **Load**
  - load=1 sets count ← load_val on the next edge.
  - Any digit > 9 in load_val is loaded as 0.
  - Load has priority over a simultaneous tick step; that step is discarded and wrap=0.
- **Scan**
  - Free-running scan counter of SCAN_LOG2 + ⌈log2 DIGITS⌉ bits.
  - Digit index advances every 2^SCAN_LOG2 cycles through 0..DIGITS-1, then returns to 0 (non-power-of-2 DIGITS wraps explicitly).
  - an[i]=0 only for the active index.
- **Decode** (combinational from registers; seg[6:0] in hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
- **Reset state**
  - count=0, tick=0, wrap=0, prescaler=0, scan=0.
  - an = all 1s except an[0]=0; seg=7'h40.
  - Reset assertion mid-operation clears everything immediately, including a pending step.

## Timing
- tick → count: count changes on the edge where tick is sampled high, i.e. the cycle after tick first reads 1.
- load: 1-cycle latency.
- wrap: coincides with the count change.
- seg/an: follow the scan index and count with zero added latency.
- en=0 on a tick cycle: that tick is lost, with no catch-up.
- Direction change takes effect on the next qualifying tick.

## Configuration
- **BCD_LEADING_ZERO_BLANK_EN defined:**
  - Digits above the most significant non-zero digit show seg=7'h7F (blank).
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - an still scans normally.
- **Undefined:** all digits are always decoded, including leading zeros.

## Test plan
- Use DIGITS=3, CLK_HZ=8, TICK_HZ=2 (DIV=4), SCAN_LOG2=2 unless noted.
- Reset, release, run 40 cycles up with en=1 → tick every 4 cycles; count steps 000→001…; after 10 ticks count=010.
- Load 998, up=1, en=1 → counts 999, then 000 with wrap=1 for exactly 1 cycle; next step 001 with wrap=0.
- Load 000, up=0 → 999 with wrap pulse, then 998.
- load=1 with load_val=12'h1A5 on a tick cycle → count=105, no step applied, wrap=0.
- Scan check, DIGITS=3, count=123 → an cycles 110→101→011→110 every 4 cycles; seg=10-series patterns 30, 24, 79 for digits 3, 2, 1.
- With BCD_LEADING_ZERO_BLANK_EN defined, count=007 → digit 2 and digit 1 seg=7F, digit 0 seg=78. Assert rst_n low mid-scan → all outputs return to reset values asynchronously.
